// File: rtl/data_sram_resp_if.sv
// CPU-side data SRAM handshake bundle: request fields from the CPU, response strobes back.
interface data_sram_resp_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        data_sram_err;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata, data_sram_err
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata, data_sram_err
  );
endinterface

// File: rtl/data_sram_resp.sv
// Single-outstanding data SRAM model with fixed response latency (DELAY+1 cycles).
// Define DATA_SRAM_RESP_ALIGN_CHK_EN to flag and suppress misaligned half/word accesses.
module data_sram_resp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DELAY  = 2
) (
  input  logic            clk,
  input  logic            resetn,
  data_sram_resp_if.slave bus
);

  localparam logic [3:0] DelayCnt = 4'(DELAY);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                mis_q, mis_d;
  logic                accept;
  logic                mis_in;

  // Contents are deliberately left unreset.
  logic [31:0] mem_q [2**ADDR_W];

`ifdef DATA_SRAM_RESP_ALIGN_CHK_EN
  logic unused_addr;
  assign unused_addr = ^bus.data_sram_addr[31:ADDR_W+2];

  always_comb begin
    mis_in = 1'b0;
    case (bus.data_sram_size)
      2'd1:    mis_in = bus.data_sram_addr[0];
      2'd2:    mis_in = (bus.data_sram_addr[1:0] != 2'b00);
      default: mis_in = 1'b0;
    endcase
  end
`else
  logic unused_addr;
  assign unused_addr = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0],
                         bus.data_sram_size};
  assign mis_in = 1'b0;
`endif

  assign bus.data_sram_addr_ok = (state_q != StWait);
  assign accept                = bus.data_sram_req && bus.data_sram_addr_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;

    case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          state_d = (DelayCnt == 4'd0) ? StResp : StWait;
          cnt_d   = DelayCnt;
          wr_d    = bus.data_sram_wr;
          wstrb_d = bus.data_sram_wstrb;
          idx_d   = bus.data_sram_addr[ADDR_W+1:2];
          wdata_d = bus.data_sram_wdata;
          mis_d   = mis_in;
        end else if (state_q == StResp) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      wstrb_q <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
    end
  end

  // The write lands on the edge that ends RESP, so a back-to-back read sees it.
  always_ff @(posedge clk) begin
    if (state_q == StResp && wr_q && !mis_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.data_sram_data_ok = (state_q == StResp);
  assign bus.data_sram_err     = (state_q == StResp) && mis_q;
  assign bus.data_sram_rdata   = (state_q == StResp && !wr_q && !mis_q) ? mem_q[idx_q] : 32'd0;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed scenarios plus random traffic against a transaction model.
module tb_data_sram_resp;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DELAY  = 2;
  localparam int unsigned WORDS  = 1 << ADDR_W;
`ifdef DATA_SRAM_RESP_ALIGN_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  data_sram_resp_if bus ();

  data_sram_resp #(
    .ADDR_W(ADDR_W),
    .DELAY (DELAY)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int resp_cyc = 0;
  int n_ok     = 0;
  int n_seen   = 0;

  bit          pend = 1'b0;
  bit          p_wr, p_mis;
  logic [3:0]  p_wstrb;
  logic [31:0] p_addr, p_wdata;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [31:0] mem_m [WORDS];

  always @(negedge clk) if (bus.data_sram_data_ok === 1'b1) n_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit misaligned(input logic [1:0] size, input logic [31:0] addr);
    bit m;
    m = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    return ChkEn && m;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  // One cycle: check what the DUT shows now, then drive the next request.
  task automatic step(input bit req, input bit wr, input logic [1:0] size,
                      input logic [3:0] wstrb, input logic [31:0] addr,
                      input logic [31:0] wdata, output bit acc);
    bit          resp_now, can_acc;
    logic [31:0] exp_rd;
    @(negedge clk);
    cyc++;
    resp_now = pend && (resp_cyc == cyc);
    can_acc  = !pend || resp_now;
    check_eq("addr_ok", 32'(bus.data_sram_addr_ok), 32'(can_acc));
    check_eq("data_ok", 32'(bus.data_sram_data_ok), 32'(resp_now));
    if (resp_now) begin
      exp_rd = (p_wr || p_mis) ? 32'd0 : mem_m[word_of(p_addr)];
      check_eq("rdata", bus.data_sram_rdata, exp_rd);
      check_eq("err", 32'(bus.data_sram_err), 32'(p_mis));
      last_rdata = bus.data_sram_rdata;
      last_err   = bus.data_sram_err;
      n_ok++;
      if (p_wr && !p_mis)
        for (int i = 0; i < 4; i++)
          if (p_wstrb[i]) mem_m[word_of(p_addr)][8*i +: 8] = p_wdata[8*i +: 8];
      pend = 1'b0;
    end
    bus.data_sram_req   = req;
    bus.data_sram_wr    = wr;
    bus.data_sram_size  = size;
    bus.data_sram_wstrb = wstrb;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    acc = req && can_acc;
    if (acc) begin
      pend     = 1'b1;
      resp_cyc = cyc + int'(DELAY) + 1;
      p_wr     = wr;
      p_wstrb  = wstrb;
      p_addr   = addr;
      p_wdata  = wdata;
      p_mis    = misaligned(size, addr);
    end
  endtask

  task automatic idle();
    bit a;
    step(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, a);
  endtask

  // Requester holds the request until accepted.
  task automatic issue(input bit wr, input logic [1:0] size, input logic [3:0] wstrb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 20) begin
      step(1'b1, wr, size, wstrb, addr, wdata, acc);
      tries++;
    end
    check_eq("accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int guard = 0;
    while (pend && guard < 40) begin
      idle();
      guard++;
    end
    idle();
  endtask

  initial begin
    int  seen0;
    bit  hold, acc, r_req, r_wr;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr, r_wdata;

    bus.data_sram_req   = 1'b0;
    bus.data_sram_wr    = 1'b0;
    bus.data_sram_size  = 2'd0;
    bus.data_sram_wstrb = 4'd0;
    bus.data_sram_addr  = 32'd0;
    bus.data_sram_wdata = 32'd0;
    #12;
    check_eq("rst_addr_ok", 32'(bus.data_sram_addr_ok), 32'd1);
    check_eq("rst_data_ok", 32'(bus.data_sram_data_ok), 32'd0);
    check_eq("rst_rdata", bus.data_sram_rdata, 32'd0);
    check_eq("rst_err", 32'(bus.data_sram_err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Initialise every word that is ever read.
    for (int w = 0; w < 8; w++) issue(1'b1, 2'd2, 4'hF, 32'(w * 4), $urandom);
    issue(1'b1, 2'd2, 4'hF, 32'h20, 32'hAABBCCDD);
    issue(1'b1, 2'd2, 4'hF, 32'h30, 32'h00000000);
    issue(1'b1, 2'd2, 4'hF, 32'h40, 32'hCAFEF00D);
    drain();

    // Full write then read; the read is held through WAIT.
    seen0 = n_seen;
    issue(1'b1, 2'd2, 4'hF, 32'h10, 32'h11223344);
    issue(1'b0, 2'd2, 4'h0, 32'h10, 32'h0);
    drain();
    check_eq("r036_rdata", last_rdata, 32'h11223344);
    check_eq("r039_dok_cnt", 32'(n_seen - seen0), 32'd2);

    // Partial-strobe write.
    issue(1'b1, 2'd2, 4'b0100, 32'h20, 32'h00EE0000);
    issue(1'b0, 2'd2, 4'h0, 32'h20, 32'h0);
    drain();
    check_eq("r037_rdata", last_rdata, 32'hAAEECCDD);

    // Read issued exactly in the RESP cycle of the write.
    issue(1'b1, 2'd2, 4'hF, 32'h10, 32'h55667788);
    idle();
    idle();
    step(1'b1, 1'b0, 2'd2, 4'h0, 32'h10, 32'h0, acc);
    drain();
    check_eq("r038_rdata", last_rdata, 32'h55667788);

    // Reset during WAIT aborts the write.
    seen0 = n_seen;
    issue(1'b1, 2'd2, 4'hF, 32'h30, 32'hDEADBEEF);
    idle();
    #2 resetn = 1'b0;
    #1;
    pend = 1'b0;
    check_eq("r040_rst_data_ok", 32'(bus.data_sram_data_ok), 32'd0);
    check_eq("r040_rst_addr_ok", 32'(bus.data_sram_addr_ok), 32'd1);
    check_eq("r040_rst_rdata", bus.data_sram_rdata, 32'd0);
    @(posedge clk);
    #1;
    check_eq("r040_rst_hold", 32'(bus.data_sram_data_ok), 32'd0);
    resetn = 1'b1;
    idle();
    idle();
    check_eq("r040_no_dok", 32'(n_seen - seen0), 32'd0);
    issue(1'b0, 2'd2, 4'h0, 32'h30, 32'h0);
    drain();
    check_eq("r040_rdata", last_rdata, 32'h00000000);

    // Misaligned word write.
    issue(1'b1, 2'd2, 4'hF, 32'h42, 32'h12345678);
    drain();
    check_eq("r041_err", 32'(last_err), 32'(ChkEn));
    issue(1'b0, 2'd2, 4'h0, 32'h40, 32'h0);
    drain();
    check_eq("r041_rdata", last_rdata, ChkEn ? 32'hCAFEF00D : 32'h12345678);

    // Random traffic over words 0..7; fields churn whenever nothing is held.
    hold = 1'b0;
    r_req = 1'b0; r_wr = 1'b0; r_size = 2'd0; r_wstrb = 4'd0; r_addr = 32'd0; r_wdata = 32'd0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        r_req   = ($urandom_range(0, 9) < 6);
        r_wr    = $urandom_range(0, 1) == 1;
        r_size  = 2'($urandom_range(0, 2));
        r_wstrb = 4'($urandom);
        r_addr  = {$urandom_range(0, 1) == 1 ? 20'hABCDE : 20'h0, 7'd0,
                   3'($urandom_range(0, 7)), 2'($urandom)};
        r_wdata = $urandom;
      end
      step(r_req, r_wr, r_size, r_wstrb, r_addr, r_wdata, acc);
      hold = r_req && !acc;
    end
    drain();
    idle();
    check_eq("dok_count", 32'(n_seen), 32'(n_ok));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-index width of internal array (2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter DELAY, default 2, extra wait cycles between request acceptance and data_ok (legal 0..15).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 data_sram_req  in  1  CPU request valid.
REQ-006 data_sram_wr  in  1  1 = write, 0 = read.
REQ-007 data_sram_size  in  2  0 = byte, 1 = half, 2 = word.
REQ-008 data_sram_wstrb  in  4  byte write enables, bit i -> bits [8i+7:8i].
REQ-009 data_sram_addr  in  32  byte address; word index = addr[ADDR_W+1:2], upper bits ignored.
REQ-010 data_sram_wdata  in  32  write data, lane-aligned.
REQ-011 data_sram_addr_ok  out  1  request accepted this cycle when high with req.
REQ-012 data_sram_data_ok  out  1  one-cycle response strobe.
REQ-013 data_sram_rdata  out  32  read data, valid only with data_ok.
REQ-014 data_sram_err  out  1  misalignment flag, valid only with data_ok.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, RESP; one request outstanding at most.
REQ-016 addr_ok SHALL be high exactly in IDLE and RESP (combinational from state).
REQ-017 Acceptance (req && addr_ok) SHALL latch wr, size, wstrb, addr, wdata and load counter with DELAY.
REQ-018 On acceptance: DELAY==0 -> next state RESP; else -> WAIT.
REQ-019 In WAIT, counter SHALL decrement each cycle; when counter==1, next state RESP.
REQ-020 Total latency acceptance edge to data_ok cycle SHALL be DELAY+1 cycles.
REQ-021 data_ok SHALL be high exactly for the one cycle in RESP.
REQ-022 Read: rdata in RESP SHALL equal full 32-bit word at latched index; CPU side performs byte/half extraction.
REQ-023 Write: array bytes with latched wstrb bit set SHALL update at the clock edge ending RESP; rdata SHALL be 0 for writes.
REQ-024 Write with wstrb==0 SHALL still complete handshake, no array change.
REQ-025 Request in RESP with req high SHALL be accepted same cycle (back-to-back); next state per REQ-018, no idle bubble.
REQ-026 RESP without new req -> IDLE.
REQ-027 Read following write to same word back-to-back SHALL return post-write data.
REQ-028 Latched request fields SHALL not change between acceptance and data_ok regardless of input activity.
REQ-029 req in WAIT SHALL be ignored (addr_ok low); requester holds it.

Reset
REQ-030 resetn low SHALL immediately force IDLE, counter 0, data_ok 0, rdata 0, err 0; addr_ok thus 1.
REQ-031 Reset mid-WAIT/RESP SHALL abort the request: no data_ok, no array write.
REQ-032 Array contents SHALL not be reset; undefined until written.

Configuration
REQ-033 Macro DATA_SRAM_RESP_ALIGN_CHK_EN SHALL gate alignment checking.
REQ-034 Defined: size 1 with addr[0]!=0, or size 2 with addr[1:0]!=0, SHALL set err=1 with data_ok; misaligned writes SHALL not modify array; misaligned reads return rdata 0.
REQ-035 Undefined: err SHALL be constant 0; all requests serviced per REQ-022/023 ignoring size.

Verification (DELAY=2, ADDR_W=10)
REQ-036 Write addr 0x10 wdata 0x11223344 wstrb 4'hF, then read 0x10 -> each data_ok 3 cycles after acceptance, read rdata 0x11223344.
REQ-037 Word 0x20 = 0xAABBCCDD; write wstrb 4'b0100 wdata 0x00EE0000; read 0x20 -> 0xAAEECCDD.
REQ-038 Back-to-back: read issued in RESP cycle of prior write to same word -> accepted that cycle (addr_ok=1), returns written value, no bubble.
REQ-039 req held through WAIT -> addr_ok 0 for 2 cycles, exactly one data_ok per accepted request.
REQ-040 resetn pulsed low during WAIT of a write to 0x30 (old 0x0) -> no data_ok; later read 0x30 -> 0x0.
REQ-041 With DATA_SRAM_RESP_ALIGN_CHK_EN: write size 2 addr 0x42 -> data_ok with err=1, word 0x40 unchanged; without macro -> err=0, write applied.
